// File: rtl/uds_reader_pkg.sv
// Shared constants and state encoding for the UDS read-once fetch sequencer.
package uds_reader_pkg;

  localparam int unsigned UDS_NUM_WORDS      = 8;
  localparam int unsigned UDS_TIMEOUT_CYCLES = 15;
  localparam int unsigned ADDR_W             = 3;
  localparam int unsigned DATA_W             = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/uds_reader.sv
// Fetches each read-once UDS word exactly once per reset and streams it out
// on a valid/ready interface; reports busy, done and a sticky error.
module uds_reader
  import uds_reader_pkg::*;
#(
  parameter int unsigned NUM_WORDS      = UDS_NUM_WORDS,
  parameter int unsigned TIMEOUT_CYCLES = UDS_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              lock,
  output logic              uds_cs,
  output logic              uds_en,
  output logic [ADDR_W-1:0] uds_address,
  input  logic [DATA_W-1:0] uds_read_data,
  input  logic              uds_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned        TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = done_q;
    err_d   = err_q;

    // A start anywhere but IDLE is a protocol error and is otherwise ignored.
    if (start && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (lock) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_READ;
            idx_d   = '0;
            tmo_d   = '0;
          end
        end
      end
      ST_READ: begin
        if (uds_ready) begin
          data_d  = uds_read_data;
          last_d  = (idx_q == LAST_IDX);
          state_d = ST_HOLD;
        end else if (tmo_q == TMO_LAST) begin
          // The core is read-once, so a stalled word cannot be retried.
          err_d   = 1'b1;
          data_d  = '0;
          last_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          // Scrub the word as soon as it is consumed so no secret lingers.
          data_d = '0;
          last_d = 1'b0;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            tmo_d   = '0;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign uds_cs      = (state_q == ST_READ);
  assign uds_en      = (state_q == ST_READ);
  assign uds_address = (state_q == ST_READ) ? idx_q : '0;
  assign out_valid   = (state_q == ST_HOLD);
  assign busy        = (state_q == ST_READ) || (state_q == ST_HOLD);
  assign out_data    = data_q;
  assign out_last    = last_q;
  assign done        = done_q;
  assign error       = err_q;

endmodule

// File: tb/tb_uds_reader.sv
// Directed bench for uds_reader with a read-once uds core model.
module tb_uds_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        lock;
  logic        uds_cs;
  logic        uds_en;
  logic [2:0]  uds_address;
  logic [31:0] uds_read_data;
  logic        uds_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  uds_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .lock         (lock),
    .uds_cs       (uds_cs),
    .uds_en       (uds_en),
    .uds_address  (uds_address),
    .uds_read_data(uds_read_data),
    .uds_ready    (uds_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  typedef struct {
    int unsigned rdy_delay;
    int unsigned stall;
    bit          poke_start;
    bit          set_lock;
    logic [31:0] exp_data;
    logic        exp_last;
  } word_vec_t;

  word_vec_t   tbl [8];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // uds core model: read-once words, configurable ready delay and stuck address
  logic [7:0]  rd_flag;
  int unsigned rd_cnt [8];
  int unsigned wait_cnt;
  int unsigned rdy_delay = 0;
  bit          stuck_en = 1'b0;
  logic [2:0]  stuck_addr = 3'd0;
  int unsigned cs_cycles = 0;
  int unsigned residue_viol = 0;

  assign uds_ready = uds_cs && uds_en && (wait_cnt >= rdy_delay) &&
                     !(stuck_en && (uds_address == stuck_addr));
  assign uds_read_data = (uds_cs && !rd_flag[uds_address]) ?
                         (32'hA000_0000 + 32'(uds_address)) : 32'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_flag  <= 8'h00;
      wait_cnt <= 0;
      for (int i = 0; i < 8; i++) rd_cnt[i] <= 0;
    end else begin
      wait_cnt <= uds_cs ? wait_cnt + 1 : 0;
      if (uds_cs && uds_en && uds_ready) begin
        rd_flag[uds_address] <= 1'b1;
        rd_cnt[uds_address]  <= rd_cnt[uds_address] + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (uds_cs) cs_cycles <= cs_cycles + 1;
  end

  always @(negedge clk) begin
    if (!out_valid && (out_data != 32'h0)) residue_viol <= residue_viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fill_tbl(input int stall_word, input int unsigned stall_n,
                          input int delay_word, input int unsigned delay_n,
                          input int poke_word, input int lock_word);
    for (int i = 0; i < 8; i++) begin
      tbl[i].rdy_delay  = (i == delay_word) ? delay_n : 0;
      tbl[i].stall      = (i == stall_word) ? stall_n : 0;
      tbl[i].poke_start = (i == poke_word);
      tbl[i].set_lock   = (i == lock_word);
      tbl[i].exp_data   = 32'hA000_0000 + 32'(i);
      tbl[i].exp_last   = (i == 7);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; lock = 1'b0; out_ready = 1'b0;
    stuck_en = 1'b0; rdy_delay = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start(input bit expect_go);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (expect_go) begin
      check("start_cs", 32'(uds_cs), 32'd1);
      check("start_addr0", 32'(uds_address), 32'd0);
    end
  endtask

  task automatic do_word(input int idx);
    int unsigned w;
    w = 0;
    rdy_delay = tbl[idx].rdy_delay;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("w%0d_latency", idx), 32'(w), 32'(tbl[idx].rdy_delay + 1));
    check($sformatf("w%0d_data", idx), out_data, tbl[idx].exp_data);
    check($sformatf("w%0d_last", idx), 32'(out_last), 32'(tbl[idx].exp_last));
    check($sformatf("w%0d_cs_in_hold", idx), 32'(uds_cs), 32'd0);
    if (tbl[idx].set_lock) lock = 1'b1;
    if (tbl[idx].poke_start) begin
      pulse_start(1'b0);
      check($sformatf("w%0d_poke_err", idx), 32'(error), 32'd1);
      check($sformatf("w%0d_poke_valid", idx), 32'(out_valid), 32'd1);
    end
    for (int s = 0; s < int'(tbl[idx].stall); s++) begin
      @(negedge clk);
      check($sformatf("w%0d_stall%0d_valid", idx, s), 32'(out_valid), 32'd1);
      check($sformatf("w%0d_stall%0d_data", idx, s), out_data, tbl[idx].exp_data);
      check($sformatf("w%0d_stall%0d_cs", idx, s), 32'(uds_cs), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("w%0d_post_valid", idx), 32'(out_valid), 32'd0);
    check($sformatf("w%0d_post_data", idx), out_data, 32'h0);
  endtask

  task automatic run_fetch(input logic exp_err);
    pulse_start(1'b1);
    for (int i = 0; i < 8; i++) do_word(i);
    check("end_done", 32'(done), 32'd1);
    check("end_error", 32'(error), 32'(exp_err));
    check("end_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("read_once_a%0d", i), 32'(rd_cnt[i]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned cs_snap;
    int unsigned n;
    reset = 1'b1; start = 1'b0; lock = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'h0);
    check("rst_cs", 32'(uds_cs), 32'd0);
    check("rst_en", 32'(uds_en), 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_addr", 32'(uds_address), 32'd0);

    // nominal fetch
    fill_tbl(-1, 0, -1, 0, -1, -1);
    run_fetch(1'b0);

    // start after completion
    cs_snap = cs_cycles;
    pulse_start(1'b0);
    repeat (3) @(negedge clk);
    check("rep_error", 32'(error), 32'd1);
    check("rep_done", 32'(done), 32'd1);
    check("rep_no_cs", 32'(cs_cycles), 32'(cs_snap));

    // backpressure, slow ready, mid-fetch start and mid-fetch lock
    do_reset();
    fill_tbl(3, 5, 5, 3, 1, 2);
    run_fetch(1'b1);

    // locked start
    do_reset();
    lock = 1'b1;
    cs_snap = cs_cycles;
    pulse_start(1'b0);
    repeat (3) @(negedge clk);
    check("lock_error", 32'(error), 32'd1);
    check("lock_busy", 32'(busy), 32'd0);
    check("lock_done", 32'(done), 32'd0);
    check("lock_no_cs", 32'(cs_cycles), 32'(cs_snap));
    lock = 1'b0;

    // timeout on word 2
    do_reset();
    fill_tbl(-1, 0, -1, 0, -1, -1);
    pulse_start(1'b1);
    do_word(0);
    do_word(1);
    stuck_en = 1'b1;
    stuck_addr = 3'd2;
    check("tmo_addr", 32'(uds_address), 32'd2);
    check("tmo_en", 32'(uds_en), 32'd1);
    n = 0;
    while (uds_cs && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("tmo_read_cycles", 32'(n), 32'd15);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_done", 32'(done), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_data", out_data, 32'h0);
    check("tmo_valid", 32'(out_valid), 32'd0);
    check("tmo_no_read_a2", 32'(rd_cnt[2]), 32'd0);
    stuck_en = 1'b0;

    // asynchronous reset while word 4 is held, then a fresh fetch
    do_reset();
    fill_tbl(-1, 0, -1, 0, -1, -1);
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) do_word(i);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mid_w4_data", out_data, 32'hA000_0004);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cs", 32'(uds_cs), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_fetch(1'b0);

    check("no_residue", 32'(residue_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
